conv_sequencer: RTL and testbench
=================================

# conv_sequencer

Cycle-budgeted run sequencer for the convolution datapath. On a `start` pulse it brings memory out of reset, releases the 1×1 PE, 3×3 systolic and 2×2 systolic engines one after another for fixed cycle budgets, then enables the display and reports completion. Engines and memory stay released after their phase so results remain stable for the display. It sits between the top-level `clk`/`rst` and the per-unit reset inputs of memory, engines and display, and replaces fixed-sequence reset generation with start/done control and per-engine skip.

## Interface
Parameters:
- `MEM_CYC`, 16: cycles memory runs before the first engine phase; legal 1..255
- `PE_CYC`, 40: 1×1 PE phase length; legal 1..255
- `SA3_CYC`, 12: 3×3 systolic phase length; legal 1..255
- `SA2_CYC`, 14: 2×2 systolic phase length; legal 1..255

Ports:
- `clk` in 1: single clock, all logic on rising edge
- `rst` in 1: synchronous, active-high reset
- `start` in 1: run request, sampled every cycle
- `run_mask` in 3: bit0 PE, bit1 3×3, bit2 2×2; 1 = run the engine; sampled only when `start` is accepted
- `rst_mem` out 1: memory reset, active-high
- `rst_pe` out 1: PE reset, active-high
- `rst_3b3` out 1: 3×3 engine reset, active-high
- `rst_2b2` out 1: 2×2 engine reset, active-high
- `rst_disp` out 1: display enable, active-low reset (drives display `resetn`); 0 = display held
- `busy` out 1: high from CLEAR through the last engine phase
- `done` out 1: one-cycle pulse on SHOW entry
- `phase` out 3: current state code
- `run_cycles` out 16: cycles spent in CLEAR..last engine phase of the most recent run

## Operation
- States and `phase` codes: IDLE=0, CLEAR=1, LOAD=2, PE=3, SA3=4, SA2=5, SHOW=6.
- IDLE: all active-high resets = 1, `rst_disp`=0, `busy`=0. `start`=1 → CLEAR; latch `run_mask`.
- CLEAR: exactly 1 cycle. All active-high resets = 1, `rst_disp`=0, `busy`=1. `run_cycles` counter cleared. → LOAD.
- LOAD: `rst_mem`=0 for `MEM_CYC` cycles. → first enabled engine phase in order PE, SA3, SA2; if none enabled → SHOW.
- Engine phase X: `rst_X`=0 for its budget, then → next enabled phase, or SHOW. A released engine stays released, and `rst_mem` stays 0, until the next CLEAR or `rst`. A disabled engine stays in reset and consumes zero cycles.
- SHOW:
  - `rst_disp`=1, `busy`=0; `done`=1 in the first SHOW cycle only.
  - Released engines and memory stay released.
  - `start`=1 → CLEAR, which is a restart.
- `start` while `busy`=1 is ignored. It is not queued.
- Phase counter: 8-bit down-counter, loaded with budget−1 on phase entry; exit when it reaches 0.
- `run_cycles`: increments every cycle with `busy`=1. It saturates at 0xFFFF and holds its value in SHOW and IDLE.
- `rst`=1 at any edge, including mid-run: next cycle state=IDLE, all active-high resets=1, `rst_disp`=0, `busy`=0, `done`=0, `phase`=0, `run_cycles`=0, latched mask=0. `rst` has priority over `start`.

## Timing
- All outputs are registered.
- Reset values: `rst_mem`/`rst_pe`/`rst_3b3`/`rst_2b2`=1, `rst_disp`=0, `busy`=0, `done`=0, `phase`=0, `run_cycles`=0.
- `start` is high in cycle 0 while in IDLE or SHOW:
  - CLEAR is cycle 1.
  - LOAD is cycles 2..MEM_CYC+1.
  - Engine phases follow back-to-back with no gap cycles.
- `done` cycle = 2 + MEM_CYC + sum of enabled budgets. `run_cycles` = that value − 1.
- Defaults with mask=111:
  - LOAD 2..17, PE 18..57, SA3 58..69, SA2 70..83.
  - SHOW, `done`, `rst_disp`=1 at cycle 84; `run_cycles`=83.
- Each reset deasserts in the first cycle of its phase. Nothing reasserts except in CLEAR, IDLE, or after `rst`.

## Test plan
- Defaults, mask=111, start at cycle 0 → `rst_pe` falls at 18, `rst_3b3` at 58, `rst_2b2` at 70; `done` a single pulse at 84; `rst_disp`=1 from 84; `run_cycles`=83; `phase` sequence 1,2,3,4,5,6.
- mask=010 → `rst_pe`/`rst_2b2` stay 1 throughout; `rst_3b3` falls at 18; `done` at 30; `run_cycles`=29.
- mask=000 → `done` at 18, `run_cycles`=17; only `rst_mem` releases.
- `start` pulses at cycles 5 and 40 during a default run → ignored; `done` still at 84 and appears once.
- `start` in SHOW at cycle 90 → cycle 91 all active-high resets=1, `rst_disp`=0, `run_cycles`=0; second `done` at 174.
- `rst` at cycle 50 mid-PE → cycle 51 matches reset values; a later `start` gives the full 84-cycle sequence again.

Source files
------------

// File: rtl/conv_sequencer.sv
// Start/done run sequencer: releases memory, then the PE, 3x3 and 2x2 engines for
// fixed cycle budgets, then enables the display. Enabled engines run in that order; disabled engines are skipped.
module conv_sequencer #(
  parameter int MEM_CYC = 16,
  parameter int PE_CYC  = 40,
  parameter int SA3_CYC = 12,
  parameter int SA2_CYC = 14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  run_mask,
  output logic        rst_mem,
  output logic        rst_pe,
  output logic        rst_3b3,
  output logic        rst_2b2,
  output logic        rst_disp,
  output logic        busy,
  output logic        done,
  output logic [2:0]  phase,
  output logic [15:0] run_cycles
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_LOAD  = 3'd2,
    S_PE    = 3'd3,
    S_SA3   = 3'd4,
    S_SA2   = 3'd5,
    S_SHOW  = 3'd6
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [2:0] mask_q;

  // First enabled phase after s; disabled engines consume no cycles.
  function automatic state_t after(input state_t s, input logic [2:0] m);
    state_t r;
    r = S_SHOW;
    case (s)
      S_LOAD:  r = m[0] ? S_PE : (m[1] ? S_SA3 : (m[2] ? S_SA2 : S_SHOW));
      S_PE:    r = m[1] ? S_SA3 : (m[2] ? S_SA2 : S_SHOW);
      S_SA3:   r = m[2] ? S_SA2 : S_SHOW;
      default: r = S_SHOW;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] budget(input state_t s);
    logic [7:0] b;
    b = 8'd0;
    case (s)
      S_LOAD:  b = 8'(MEM_CYC - 1);
      S_PE:    b = 8'(PE_CYC - 1);
      S_SA3:   b = 8'(SA3_CYC - 1);
      S_SA2:   b = 8'(SA2_CYC - 1);
      default: b = 8'd0;
    endcase
    return b;
  endfunction

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE, S_SHOW: if (start) state_nxt = S_CLEAR;
      S_CLEAR:        state_nxt = S_LOAD;
      S_LOAD, S_PE, S_SA3, S_SA2: begin
        if (cnt == 8'd0) state_nxt = after(state, mask_q);
        else             cnt_nxt   = cnt - 8'd1;
      end
      default:        state_nxt = S_IDLE;
    endcase
    // Down-counter reloads with budget-1 on every phase entry.
    if (state_nxt != state) cnt_nxt = budget(state_nxt);
  end

  // All outputs are registered from the next state so they line up with the phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= 8'd0;
      mask_q     <= 3'b000;
      rst_mem    <= 1'b1;
      rst_pe     <= 1'b1;
      rst_3b3    <= 1'b1;
      rst_2b2    <= 1'b1;
      rst_disp   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      phase      <= 3'd0;
      run_cycles <= 16'd0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      phase    <= state_nxt;
      busy     <= (state_nxt != S_IDLE) && (state_nxt != S_SHOW);
      done     <= (state_nxt == S_SHOW) && (state != S_SHOW);
      rst_disp <= (state_nxt == S_SHOW);
      if (state_nxt == S_CLEAR && state != S_CLEAR) mask_q <= run_mask;

      // Resets only reassert in IDLE/CLEAR; otherwise a released unit stays released.
      case (state_nxt)
        S_IDLE, S_CLEAR: begin
          rst_mem <= 1'b1;
          rst_pe  <= 1'b1;
          rst_3b3 <= 1'b1;
          rst_2b2 <= 1'b1;
        end
        S_LOAD:  rst_mem <= 1'b0;
        S_PE:    rst_pe  <= 1'b0;
        S_SA3:   rst_3b3 <= 1'b0;
        S_SA2:   rst_2b2 <= 1'b0;
        default: ;
      endcase

      // busy here is the current cycle's value, so CLEAR itself is counted.
      if (state_nxt == S_CLEAR && state != S_CLEAR) run_cycles <= 16'd0;
      else if (busy && run_cycles != 16'hFFFF)      run_cycles <= run_cycles + 16'd1;
    end
  end

endmodule

// File: tb/tb_conv_sequencer.sv
// Directed bench for conv_sequencer: default run, restart with ignored starts,
// partial masks, empty mask and a mid-run reset, all against hand-derived cycle numbers.
module tb_conv_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  run_mask;
  logic        rst_mem, rst_pe, rst_3b3, rst_2b2, rst_disp;
  logic        busy, done;
  logic [2:0]  phase;
  logic [15:0] run_cycles;

  int errors = 0;
  int checks = 0;

  // Per-run observations, cycle numbers relative to the start cycle (0).
  int   t_mem, t_pe, t_3b3, t_2b2, t_done, t_disp, done_cnt, reassert;
  logic [23:0] seq;

  conv_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .run_mask   (run_mask),
    .rst_mem    (rst_mem),
    .rst_pe     (rst_pe),
    .rst_3b3    (rst_3b3),
    .rst_2b2    (rst_2b2),
    .rst_disp   (rst_disp),
    .busy       (busy),
    .done       (done),
    .phase      (phase),
    .run_cycles (run_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_rst_mem"},  rst_mem,    1);
    check({tag, "_rst_pe"},   rst_pe,     1);
    check({tag, "_rst_3b3"},  rst_3b3,    1);
    check({tag, "_rst_2b2"},  rst_2b2,    1);
    check({tag, "_rst_disp"}, rst_disp,   0);
    check({tag, "_busy"},     busy,       0);
    check({tag, "_done"},     done,       0);
    check({tag, "_phase"},    phase,      0);
    check({tag, "_cycles"},   run_cycles, 0);
  endtask

  // Start pulse in cycle 0 (IDLE or SHOW); returns in cycle 1 after checking CLEAR.
  task automatic launch(input string tag, input logic [2:0] m);
    run_mask = m;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    run_mask = ~m;
    check({tag, "_clr_phase"},  phase,      1);
    check({tag, "_clr_busy"},   busy,       1);
    check({tag, "_clr_cycles"}, run_cycles, 0);
    check({tag, "_clr_resets"}, {rst_mem, rst_pe, rst_3b3, rst_2b2}, 4'b1111);
    check({tag, "_clr_disp"},   rst_disp,   0);
  endtask

  // Samples cycles 1..n, pulsing start in cycles pa/pb, and records edge times.
  task automatic observe(input int n, input int pa, input int pb);
    logic [3:0] prev;
    logic [2:0] last_ph;
    t_mem = -1; t_pe = -1; t_3b3 = -1; t_2b2 = -1;
    t_done = -1; t_disp = -1; done_cnt = 0; reassert = 0;
    seq = 24'o1; last_ph = 3'd1; prev = 4'b1111;
    for (int i = 0; i < n; i++) begin
      int c;
      c = i + 1;
      start = (c == pa) || (c == pb);
      if (rst_mem == 1'b0 && t_mem < 0) t_mem = c;
      if (rst_pe  == 1'b0 && t_pe  < 0) t_pe  = c;
      if (rst_3b3 == 1'b0 && t_3b3 < 0) t_3b3 = c;
      if (rst_2b2 == 1'b0 && t_2b2 < 0) t_2b2 = c;
      if (rst_disp == 1'b1 && t_disp < 0) t_disp = c;
      if (done === 1'b1) begin
        done_cnt++;
        if (t_done < 0) t_done = c;
      end
      if ((~prev & {rst_mem, rst_pe, rst_3b3, rst_2b2}) != 4'b0000) reassert++;
      prev = {rst_mem, rst_pe, rst_3b3, rst_2b2};
      if (phase != last_ph) begin
        seq = (seq << 3) | 24'(phase);
        last_ph = phase;
      end
      tick();
    end
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    run_mask = 3'b000;
    tick(); tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    rst = 1'b0;
    check_reset("por");
    tick();
    check("idle_phase", phase, 0);

    // Default run, mask=111.
    launch("a", 3'b111);
    observe(89, -1, -1);
    check("a_mem_fall",  t_mem,  2);
    check("a_pe_fall",   t_pe,   18);
    check("a_3b3_fall",  t_3b3,  58);
    check("a_2b2_fall",  t_2b2,  70);
    check("a_done_at",   t_done, 84);
    check("a_done_cnt",  done_cnt, 1);
    check("a_disp_at",   t_disp, 84);
    check("a_seq",       seq, 24'o123456);
    check("a_reassert",  reassert, 0);
    check("a_cycles",    run_cycles, 83);
    check("a_show_busy", busy, 0);
    check("a_show_held", {rst_mem, rst_pe, rst_3b3, rst_2b2, rst_disp}, 5'b00001);

    // Restart from SHOW at cycle 90; starts at relative 5 and 40 are ignored.
    launch("b", 3'b111);
    observe(89, 5, 40);
    check("b_done_at",  t_done, 84);
    check("b_done_cnt", done_cnt, 1);
    check("b_seq",      seq, 24'o123456);
    check("b_cycles",   run_cycles, 83);

    // Only the 3x3 engine.
    launch("c", 3'b010);
    observe(39, -1, -1);
    check("c_pe_never",  t_pe,   -1);
    check("c_3b3_fall",  t_3b3,  18);
    check("c_2b2_never", t_2b2,  -1);
    check("c_done_at",   t_done, 30);
    check("c_seq",       seq, 24'o1246);
    check("c_cycles",    run_cycles, 29);

    // No engines.
    launch("d", 3'b000);
    observe(29, -1, -1);
    check("d_mem_fall", t_mem, 2);
    check("d_engines",  {rst_pe, rst_3b3, rst_2b2}, 3'b111);
    check("d_done_at",  t_done, 18);
    check("d_seq",      seq, 24'o126);
    check("d_cycles",   run_cycles, 17);

    // Reset at cycle 50 mid-PE, with start also high: reset wins.
    launch("e", 3'b111);
    observe(49, -1, -1);
    check("e_pre_phase", phase, 3);
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    check_reset("mid");
    tick();
    check("mid_idle", phase, 0);
    launch("f", 3'b111);
    observe(89, -1, -1);
    check("f_pe_fall",  t_pe,   18);
    check("f_done_at",  t_done, 84);
    check("f_done_cnt", done_cnt, 1);
    check("f_seq",      seq, 24'o123456);
    check("f_cycles",   run_cycles, 83);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
